// File: rtl/qubo_demon_scheduler.sv
// QUBO demon annealer sequencer: sweeps the spins, streams weight rows, applies the demon flip rule.
// Optional best-state tracking is built when QUBO_DEMON_BEST_EN is defined.
module qubo_demon_scheduler #(
    parameter int N_SPINS   = 8,
    parameter int W_WIDTH   = 8,
    parameter int E_WIDTH   = 12,
    parameter int DEMON_MAX = 255,
    localparam int IDX_W    = $clog2(N_SPINS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         sweeps,
    input  logic [N_SPINS-1:0] spin_init,
    input  logic [E_WIDTH-1:0] demon_init,
    output logic [IDX_W-1:0]   w_row,
    output logic [IDX_W-1:0]   w_col,
    input  logic [W_WIDTH-1:0] w_data,
    output logic               busy,
    output logic               done,
    output logic [N_SPINS-1:0] spins,
    output logic [E_WIDTH-1:0] demon,
    output logic [15:0]        flip_count,
    output logic [N_SPINS-1:0] best_spins,
    output logic [E_WIDTH-1:0] best_delta,
    output logic [1:0]         dbg_state
);

    localparam int CNT_W = IDX_W + 1;
    localparam int X_W   = E_WIDTH + 2;
    localparam logic signed [X_W-1:0] E_MAX_X = X_W'((2 ** (E_WIDTH - 1)) - 1);
    localparam logic signed [X_W-1:0] E_MIN_X = -E_MAX_X - X_W'(1);
    localparam logic signed [X_W-1:0] DMAX_X  = X_W'(DEMON_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [E_WIDTH-1:0] sat_e(input logic signed [X_W-1:0] v);
        if (v > E_MAX_X)      return E_MAX_X[E_WIDTH-1:0];
        else if (v < E_MIN_X) return E_MIN_X[E_WIDTH-1:0];
        else                  return v[E_WIDTH-1:0];
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_i;
    logic [CNT_W-1:0]     r_j;
    logic [7:0]           r_sweeps_left;
    logic [E_WIDTH-1:0]   r_acc;
    logic [N_SPINS-1:0]   r_spins;
    logic [E_WIDTH-1:0]   r_demon;
    logic [15:0]          r_flips;

    logic                 w_fetch_last;
    logic                 w_last_i;
    logic                 w_last_sweep;
    logic [IDX_W-1:0]     w_acc_col;
    logic signed [X_W-1:0] w_dext;
    logic signed [X_W-1:0] w_acc_x;
    logic signed [X_W-1:0] w_term;
    logic [E_WIDTH-1:0]   w_acc_nxt;
    logic signed [E_WIDTH-1:0] w_de;
    logic                 w_accept;
    logic signed [X_W-1:0] w_dem_diff;
    logic [E_WIDTH-1:0]   w_dem_nxt;
    logic [N_SPINS-1:0]   w_spins_flip;

    assign w_fetch_last = (r_j == CNT_W'(N_SPINS));
    assign w_last_i     = (r_i == IDX_W'(N_SPINS - 1));
    assign w_last_sweep = (r_sweeps_left == 8'd1);

    // Data returned this cycle belongs to the column issued one cycle earlier.
    assign w_acc_col = IDX_W'(r_j - CNT_W'(1));
    assign w_dext    = {{(X_W - W_WIDTH){w_data[W_WIDTH-1]}}, w_data};
    assign w_acc_x   = {{2{r_acc[E_WIDTH-1]}}, r_acc};

    always_comb begin
        w_term = '0;
        if (w_acc_col == r_i)
            w_term = w_dext;
        else if (r_spins[w_acc_col])
            w_term = w_dext <<< 1;
    end

    assign w_acc_nxt    = sat_e(w_acc_x + w_term);
    assign w_de         = sat_e(r_spins[r_i] ? -w_acc_x : w_acc_x);
    assign w_accept     = (w_de <= $signed(r_demon));
    assign w_dem_diff   = $signed({2'b00, r_demon}) - {{2{w_de[E_WIDTH-1]}}, w_de};
    assign w_dem_nxt    = (w_dem_diff > DMAX_X) ? DMAX_X[E_WIDTH-1:0] :
                          (w_dem_diff < 0)      ? '0 : w_dem_diff[E_WIDTH-1:0];
    assign w_spins_flip = r_spins ^ (N_SPINS'(1) << r_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = (sweeps == 8'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (w_fetch_last) w_state_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                busy        = 1'b1;
                w_state_nxt = (w_last_i && w_last_sweep) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i           <= '0;
            r_j           <= '0;
            r_sweeps_left <= '0;
            r_acc         <= '0;
            r_spins       <= '0;
            r_demon       <= '0;
            r_flips       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sweeps_left <= sweeps;
                        r_spins       <= spin_init;
                        r_demon       <= (demon_init > E_WIDTH'(DEMON_MAX)) ? E_WIDTH'(DEMON_MAX) : demon_init;
                        r_flips       <= '0;
                        r_i           <= '0;
                        r_j           <= '0;
                        r_acc         <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_j != '0) r_acc <= w_acc_nxt;
                    r_j <= w_fetch_last ? '0 : r_j + CNT_W'(1);
                end
                S_DECIDE: begin
                    if (w_accept) begin
                        r_spins <= w_spins_flip;
                        r_demon <= w_dem_nxt;
                        if (r_flips != 16'hFFFF) r_flips <= r_flips + 16'd1;
                    end
                    r_acc <= '0;
                    r_j   <= '0;
                    if (w_last_i) begin
                        r_i <= '0;
                        if (!w_last_sweep) r_sweeps_left <= r_sweeps_left - 8'd1;
                    end else begin
                        r_i <= r_i + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_row      = r_i;
    assign w_col      = (r_state == S_FETCH && !w_fetch_last) ? r_j[IDX_W-1:0] : '0;
    assign spins      = r_spins;
    assign demon      = r_demon;
    assign flip_count = r_flips;
    assign dbg_state  = r_state;

`ifdef QUBO_DEMON_BEST_EN
    logic [E_WIDTH-1:0] r_rel_e;
    logic [N_SPINS-1:0] r_best_spins;
    logic [E_WIDTH-1:0] r_best_delta;
    logic [E_WIDTH-1:0] w_rel_nxt;

    // rel_E is the energy of the current spins relative to spin_init.
    assign w_rel_nxt = sat_e({{2{r_rel_e[E_WIDTH-1]}}, r_rel_e} + {{2{w_de[E_WIDTH-1]}}, w_de});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rel_e      <= '0;
            r_best_spins <= '0;
            r_best_delta <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_rel_e      <= '0;
            r_best_spins <= spin_init;
            r_best_delta <= '0;
        end else if (r_state == S_DECIDE && w_accept) begin
            r_rel_e <= w_rel_nxt;
            if ($signed(w_rel_nxt) < $signed(r_best_delta)) begin
                r_best_spins <= w_spins_flip;
                r_best_delta <= w_rel_nxt;
            end
        end
    end

    assign best_spins = r_best_spins;
    assign best_delta = r_best_delta;
`else
    assign best_spins = r_spins;
    assign best_delta = '0;
`endif

endmodule

// File: tb/tb_qubo_demon_scheduler.sv
// Bench for qubo_demon_scheduler (N_SPINS=2): vector table, reference model scoreboard, reset and start corner cases.
module tb_qubo_demon_scheduler;

    localparam int N  = 2;
    localparam int WW = 8;
    localparam int EW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    sweeps;
    logic [N-1:0]  spin_init;
    logic [EW-1:0] demon_init;
    logic [0:0]    w_row;
    logic [0:0]    w_col;
    logic [WW-1:0] w_data;
    logic          busy;
    logic          done;
    logic [N-1:0]  spins;
    logic [EW-1:0] demon;
    logic [15:0]   flip_count;
    logic [N-1:0]  best_spins;
    logic [EW-1:0] best_delta;
    logic [1:0]    dbg_state;

    qubo_demon_scheduler #(.N_SPINS(N), .W_WIDTH(WW), .E_WIDTH(EW), .DEMON_MAX(255)) dut (
        .clk(clk), .reset(reset), .start(start), .sweeps(sweeps),
        .spin_init(spin_init), .demon_init(demon_init),
        .w_row(w_row), .w_col(w_col), .w_data(w_data),
        .busy(busy), .done(done), .spins(spins), .demon(demon),
        .flip_count(flip_count), .best_spins(best_spins), .best_delta(best_delta),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous-read weight memory.
    logic [WW-1:0] q_mem [0:1][0:1];
    always @(posedge clk) w_data <= q_mem[w_row][w_col];

    int n_checks = 0;
    int n_pass   = 0;
    logic [45:0] exp_q[$];

    typedef struct {
        int       q00, q01, q11;
        logic [1:0] si;
        int       di, sw;
        logic [1:0] es;
        int       ed, ef, eb;
    } vec_t;

    vec_t tv[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [45:0] model(input int q00, q01, q11, input logic [1:0] si, input int di, sw);
        int m[2][2];
        logic [1:0] x;
        int d, fc, acc, de;
        m[0][0] = q00; m[0][1] = q01; m[1][0] = q01; m[1][1] = q11;
        x  = si;
        d  = (di > 255) ? 255 : di;
        fc = 0;
        for (int s = 0; s < sw; s++) begin
            for (int i = 0; i < 2; i++) begin
                acc = 0;
                for (int j = 0; j < 2; j++) begin
                    if (j == i) acc += m[i][j];
                    else if (x[j]) acc += 2 * m[i][j];
                end
                de = x[i] ? -acc : acc;
                if (de <= d) begin
                    x[i] = ~x[i];
                    d = d - de;
                    if (d > 255) d = 255;
                    fc++;
                end
            end
        end
        return {x, 12'(d), 16'(fc), 16'(sw * 8)};
    endfunction

    task automatic run_vec(input vec_t v, input int glitch, input string tag);
        int busy_cnt, cyc;
        bit addr_seen;
        logic [45:0] e;
        q_mem[0][0] = 8'(v.q00); q_mem[0][1] = 8'(v.q01);
        q_mem[1][0] = 8'(v.q01); q_mem[1][1] = 8'(v.q11);
        exp_q.push_back({v.es, 12'(v.ed), 16'(v.ef), 16'(v.eb)});
        @(negedge clk);
        start = 1'b1; sweeps = 8'(v.sw); spin_init = v.si; demon_init = 12'(v.di);
        @(negedge clk);
        start = 1'b0;
        sweeps = 8'($urandom_range(255)); spin_init = 2'($urandom_range(3)); demon_init = 12'($urandom_range(4095));
        busy_cnt = 0; cyc = 0; addr_seen = 0;
        while (cyc < 2000) begin
            if (done) break;
            if (busy) busy_cnt++;
            if (w_row != 0 || w_col != 0) addr_seen = 1;
            start = (glitch != 0 && cyc == glitch);
            if (start) begin sweeps = 8'd7; spin_init = ~v.si; end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, int'(done), 1);
        e = exp_q.pop_front();
        check({tag, " spins"}, int'(spins), int'(e[45:44]));
        check({tag, " demon"}, int'(demon), int'(e[43:32]));
        check({tag, " flips"}, int'(flip_count), int'(e[31:16]));
        check({tag, " busy_cycles"}, busy_cnt, int'(e[15:0]));
        check({tag, " latency"}, cyc, int'(e[15:0]));
        if (v.sw == 0) check({tag, " no_addr"}, int'(addr_seen), 0);
`ifndef QUBO_DEMON_BEST_EN
        check({tag, " best_spins"}, int'(best_spins), int'(e[45:44]));
        check({tag, " best_delta"}, int'(best_delta), 0);
`endif
        @(negedge clk);
        check({tag, " done_pulse_end"}, int'(done), 0);
        check({tag, " busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int dcnt;
        reset = 1'b1; start = 1'b0; sweeps = '0; spin_init = '0; demon_init = '0;
        q_mem[0][0] = '0; q_mem[0][1] = '0; q_mem[1][0] = '0; q_mem[1][1] = '0;
        repeat (3) @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst spins", int'(spins), 0);
        check("rst demon", int'(demon), 0);
        check("rst flips", int'(flip_count), 0);
        check("rst addr", int'({w_row, w_col}), 0);
        check("rst best_delta", int'(best_delta), 0);
        reset = 1'b0;

        tv[0] = '{q00:-3,   q01:0,  q11:2,   si:2'b00, di:0,    sw:1, es:2'b11, ed:1,   ef:2, eb:8};
        tv[1] = '{q00:5,    q01:0,  q11:5,   si:2'b00, di:4,    sw:3, es:2'b00, ed:4,   ef:0, eb:24};
        tv[2] = '{q00:1,    q01:-2, q11:1,   si:2'b10, di:0,    sw:1, es:2'b01, ed:0,   ef:2, eb:8};
        tv[3] = '{q00:-100, q01:0,  q11:127, si:2'b00, di:200,  sw:1, es:2'b11, ed:128, ef:2, eb:8};
        tv[4] = '{q00:5,    q01:0,  q11:5,   si:2'b00, di:4000, sw:1, es:2'b11, ed:245, ef:2, eb:8};
        tv[5] = '{q00:3,    q01:1,  q11:3,   si:2'b10, di:50,   sw:0, es:2'b10, ed:50,  ef:0, eb:0};
        for (int k = 6; k < 10; k++) begin
            logic [45:0] m;
            tv[k].q00 = int'($urandom_range(40)) - 20;
            tv[k].q01 = int'($urandom_range(40)) - 20;
            tv[k].q11 = int'($urandom_range(40)) - 20;
            tv[k].si  = 2'($urandom_range(3));
            tv[k].di  = int'($urandom_range(300));
            tv[k].sw  = int'($urandom_range(3, 1));
            m = model(tv[k].q00, tv[k].q01, tv[k].q11, tv[k].si, tv[k].di, tv[k].sw);
            tv[k].es = m[45:44]; tv[k].ed = int'(m[43:32]); tv[k].ef = int'(m[31:16]); tv[k].eb = int'(m[15:0]);
        end

        for (int k = 0; k < 10; k++) begin
            run_vec(tv[k], 0, $sformatf("vec%0d", k));
`ifdef QUBO_DEMON_BEST_EN
            if (k == 2) begin
                check("vec2 best_spins", int'(best_spins), 3);
                check("vec2 best_delta", int'($signed(best_delta)), -3);
            end
`endif
        end

        // Reset during FETCH of the second sweep aborts without a done pulse.
        q_mem[0][0] = 8'(-3); q_mem[0][1] = '0; q_mem[1][0] = '0; q_mem[1][1] = 8'd2;
        @(negedge clk);
        start = 1'b1; sweeps = 8'd2; spin_init = 2'b00; demon_init = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort in_fetch", int'(dbg_state), 1);
        reset = 1'b1;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort spins", int'(spins), 0);
        check("abort demon", int'(demon), 0);
        check("abort flips", int'(flip_count), 0);
        check("abort state", int'(dbg_state), 0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort no_done", dcnt, 0);
        run_vec(tv[0], 0, "post_abort");

        // A start pulse mid-run must not disturb the run.
        run_vec(tv[0], 3, "start_glitch");
        run_vec(tv[1], 13, "start_glitch3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
